inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch unit that produces the 32-bit instruction word consumed by the instruction decoder. It owns the program counter and issues single-outstanding reads to instruction memory. It presents each fetched word with a valid/ready handshake and honours the decoder's branch stall by holding the next fetch until the branch outcome is resolved downstream.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
NOP_INST, 32'h0000_0013, instruction word driven on inst while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction-memory read request
imem_addr  output  32  read address (word aligned)
imem_ready  input  1  memory returns data this cycle (valid only while imem_req=1)
imem_rdata  input  32  instruction word, sampled when imem_req & imem_ready
inst  output  32  instruction to decoder
inst_pc  output  32  PC of inst
inst_valid  output  1  inst holds a fetched instruction
dec_ready  input  1  decoder/pipeline accepts inst this cycle
stall  input  1  decoder branch stall for current inst (sampled with the handshake)
br_resolve  input  1  branch outcome valid this cycle
br_taken  input  1  branch taken, valid with br_resolve
br_target  input  32  taken target, valid with br_resolve
misalign_err  output  1  one-cycle pulse: br_target[1:0] was non-zero

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC.
  - inst=NOP_INST, inst_pc=RESET_PC, inst_valid=0, misalign_err=0.
  - imem_req rises on the first clock edge after rst deasserts.
- All outputs are registered; imem_addr always equals pc.
- States: FETCH, HOLD, BRWAIT.
- FETCH:
  - imem_req=1; imem_addr held stable until imem_ready.
  - On imem_ready=1: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, imem_req<=0, go to HOLD.
  - Any number of wait cycles is allowed. Zero-wait memory yields one instruction per 2 cycles.
- HOLD:
  - inst, inst_pc and inst_valid stay stable until dec_ready=1.
  - On dec_ready=1 with stall=0: pc<=pc+4, inst_valid<=0, inst<=NOP_INST, go to FETCH.
  - On dec_ready=1 with stall=1: inst_valid<=0, inst<=NOP_INST, go to BRWAIT. pc is unchanged; it still equals the branch PC.
  - stall is ignored while dec_ready=0.
- BRWAIT:
  - imem_req=0.
  - On br_resolve=1, next state is FETCH, and:
    - pc<=br_taken ? {br_target[31:2],2'b00} : pc+4.
  - If br_taken=1 and br_target[1:0]!=0: misalign_err=1 for exactly one cycle. The target is still forced aligned.
  - br_resolve is ignored in FETCH and HOLD; br_taken/br_target are don't-care without br_resolve.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000. No overflow flag.
- imem_ready while imem_req=0 is ignored; no data is captured.
- Reset mid-fetch or mid-BRWAIT: the request is abandoned immediately (imem_req=0 asynchronously) and all state returns to reset values. A late imem_ready is ignored.
- Only one outstanding request; no prefetch buffer, no speculative fetch past a branch.

Test Plan:
- Reset release with zero-wait memory returning imem_rdata=addr^32'hA5A5_0000 and dec_ready=1 -> imem_addr sequence 0,4,8 on successive FETCH cycles; inst_valid high every 2nd cycle; inst_pc matches.
- imem_ready held low 3 cycles at addr 0x8 -> imem_addr stays 0x8 and imem_req=1 for 4 cycles; inst_valid=0 throughout; capture on the 4th cycle.
- dec_ready low 5 cycles while inst_valid=1 -> inst, inst_pc and inst_valid unchanged; no new imem_req until dec_ready=1.
- Branch at PC 0x10 (stall=1 at handshake), br_resolve after 2 cycles:
  - br_taken=1, br_target=0x40 -> next imem_addr=0x40.
  - Repeat with br_taken=0 -> next imem_addr=0x14.
  - No imem_req during BRWAIT in either case.
- br_taken=1, br_target=0x0000_0046 -> misalign_err high exactly one cycle; next imem_addr=0x44.
- RESET_PC=32'hFFFF_FFFC, sequential fetch -> second imem_addr=0x0. Separately, assert rst during a FETCH wait -> imem_req=0 immediately; after release, fetch restarts at RESET_PC with inst=NOP_INST, inst_valid=0.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch unit feeding the decoder.
// Owns the program counter, issues one outstanding read at a time to
// instruction memory, and presents each fetched word with a valid/ready
// handshake. A decoder stall at the handshake parks the unit until the
// branch outcome arrives, so nothing is fetched past an unresolved branch.
//
// Ports:
//   clk          core clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   imem_req     instruction-memory read request
//   imem_addr    read address, always equal to the PC
//   imem_ready   memory returns data this cycle (only meaningful with imem_req)
//   imem_rdata   instruction word from memory
//   inst         instruction to decoder (NOP_INST when nothing is held)
//   inst_pc      PC of inst
//   inst_valid   inst holds a fetched instruction
//   dec_ready    decoder accepts inst this cycle
//   stall        branch stall for the current inst, sampled with the handshake
//   br_resolve   branch outcome valid this cycle
//   br_taken     branch taken, valid with br_resolve
//   br_target    taken target, valid with br_resolve
//   misalign_err one-cycle pulse when a taken target had non-zero low bits
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        stall,
  input  logic        br_resolve,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    BRWAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  // Next-state, PC and output-register computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    mis_d     = 1'b0;
    case (state_q)
      FETCH: begin
        // req_q is low only on the first cycle after reset; ready is ignored then.
        if (req_q && imem_ready) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d   = FETCH;
        end
      end
      HOLD: begin
        if (dec_ready) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          if (stall) begin
            // PC stays on the branch so a not-taken outcome can step past it.
            state_d = BRWAIT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end else begin
          state_d = HOLD;
        end
      end
      BRWAIT: begin
        if (br_resolve) begin
          state_d = FETCH;
          if (br_taken) begin
            pc_d  = {br_target[31:2], 2'b00};
            mis_d = |br_target[1:0];
          end else begin
            pc_d  = pc_q + 32'd4;
          end
        end else begin
          state_d = BRWAIT;
        end
      end
      default: begin
        // Unreachable encoding: drop any held word and restart fetching.
        state_d = FETCH;
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end
    endcase
    // The request register tracks the next state, so it rises one edge
    // after reset release and whenever the unit re-enters FETCH.
    req_d = (state_d == FETCH);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_valid   = valid_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst, inst_w;
  logic [31:0] inst_pc, inst_pc_w;
  logic        inst_valid, inst_valid_w;
  logic        dec_ready;
  logic        stall;
  logic        br_resolve;
  logic        br_taken;
  logic [31:0] br_target;
  logic        misalign_err, misalign_err_w;

  int n_total;
  int n_bad;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .dec_ready(dec_ready), .stall(stall),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
    .misalign_err(misalign_err)
  );

  // Second instance starting near the top of the address space; it runs in
  // lockstep with the first because its timing does not depend on the PC.
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst_w), .inst_pc(inst_pc_w), .inst_valid(inst_valid_w),
    .dec_ready(dec_ready), .stall(stall),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
    .misalign_err(misalign_err_w)
  );

  // Memory model: each word is its own address salted with a constant.
  assign imem_rdata = imem_addr ^ SALT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // In FETCH with a zero-wait memory: check the request, then the capture.
  task automatic fetch_cap(input logic [31:0] pc);
    chk_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    chk_eq("fetch_addr", imem_addr, pc);
    chk_eq("fetch_nvalid", {31'd0, inst_valid}, 32'd0);
    step();
    chk_eq("cap_valid", {31'd0, inst_valid}, 32'd1);
    chk_eq("cap_inst", inst, pc ^ SALT);
    chk_eq("cap_pc", inst_pc, pc);
    chk_eq("cap_req", {31'd0, imem_req}, 32'd0);
  endtask

  // In HOLD with dec_ready=1 and stall=0: hand off and return to FETCH.
  task automatic advance();
    step();
    chk_eq("adv_valid", {31'd0, inst_valid}, 32'd0);
    chk_eq("adv_inst", inst, NOP);
  endtask

  // In HOLD: stall at the handshake, wait two cycles, resolve, then fetch.
  task automatic branch(input logic taken, input logic [31:0] tgt,
                        input logic [31:0] exp_pc, input logic exp_mis);
    logic [31:0] bpc;
    bpc   = inst_pc;
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk_eq("bw_req0", {31'd0, imem_req}, 32'd0);
    chk_eq("bw_valid", {31'd0, inst_valid}, 32'd0);
    chk_eq("bw_inst", inst, NOP);
    chk_eq("bw_pc", imem_addr, bpc);
    step();
    chk_eq("bw_req1", {31'd0, imem_req}, 32'd0);
    br_resolve = 1'b1;
    br_taken   = taken;
    br_target  = tgt;
    step();
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'hDEAD_BEEF;
    chk_eq("br_mis", {31'd0, misalign_err}, {31'd0, exp_mis});
    fetch_cap(exp_pc);
    chk_eq("br_mis_end", {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b0;
    imem_ready = 1'b1;
    dec_ready  = 1'b1;
    stall      = 1'b0;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0000_0000;
    #1 rst = 1'b1;
    step();
    step();
    chk_eq("rst_req", {31'd0, imem_req}, 32'd0);
    chk_eq("rst_addr", imem_addr, 32'h0000_0000);
    chk_eq("rst_inst", inst, NOP);
    chk_eq("rst_ipc", inst_pc, 32'h0000_0000);
    chk_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk_eq("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk_eq("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);
    rst = 1'b0;
    chk_eq("rel_req", {31'd0, imem_req}, 32'd0);
    step();
    // Sequential fetch with zero-wait memory: one word per two cycles.
    fetch_cap(32'h0000_0000);
    chk_eq("wrap_cap_w", inst_pc_w, 32'hFFFF_FFFC);
    advance();
    chk_eq("wrap_addr_w", imem_addr_w, 32'h0000_0000);
    fetch_cap(32'h0000_0004);
    advance();
    // Wait states at 0x8: ready low for three cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("ws_req", {31'd0, imem_req}, 32'd1);
      chk_eq("ws_addr", imem_addr, 32'h0000_0008);
      chk_eq("ws_valid", {31'd0, inst_valid}, 32'd0);
      step();
    end
    imem_ready = 1'b1;
    fetch_cap(32'h0000_0008);
    // Decoder back-pressure for five cycles; stall must be ignored meanwhile.
    dec_ready = 1'b0;
    stall     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk_eq("bp_inst", inst, 32'h0000_0008 ^ SALT);
      chk_eq("bp_pc", inst_pc, 32'h0000_0008);
      chk_eq("bp_req", {31'd0, imem_req}, 32'd0);
    end
    dec_ready = 1'b1;
    stall     = 1'b0;
    advance();
    fetch_cap(32'h0000_000C);
    advance();
    fetch_cap(32'h0000_0010);
    // Branches: taken, misaligned taken, back to 0x10, then not taken.
    branch(1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0);
    branch(1'b1, 32'h0000_0046, 32'h0000_0044, 1'b1);
    branch(1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0);
    branch(1'b0, 32'h0000_0003, 32'h0000_0014, 1'b0);
    advance();
    // Reset in the middle of a fetch wait.
    imem_ready = 1'b0;
    step();
    chk_eq("mid_req", {31'd0, imem_req}, 32'd1);
    chk_eq("mid_addr", imem_addr, 32'h0000_0018);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_req", {31'd0, imem_req}, 32'd0);
    chk_eq("arst_addr", imem_addr, 32'h0000_0000);
    imem_ready = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("late_req", {31'd0, imem_req}, 32'd0);
    chk_eq("late_valid", {31'd0, inst_valid}, 32'd0);
    chk_eq("late_inst", inst, NOP);
    step();
    fetch_cap(32'h0000_0000);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
